mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Parametrised byte-serial memory controller between NUM_CH requesters (icache, dcache, ...) and the 8-bit RAM/IO bus.
// Serialises multi-byte reads and writes, and arbitrates round-robin between requesters.
// Stalls IO writes on a full UART buffer and aborts speculative reads on a clear.
// Pausing on readyIn is handled without losing bytes.
// PARAMETERS
// NUM_CH      2      number of requester channels (>=1)
// MAX_LEN     16     max bytes per transaction (power of 2); LEN_W = $clog2(MAX_LEN)
// IO_GAP      1      idle cycles inserted after every IO write byte (UART full-flag lag)
// CLEAR_MASK  'b10   bit i set: channel i reads are aborted by clearIn
// PORTS
// clockIn      in   1                 clock
// resetIn      in   1                 asynchronous, active-low reset
// readyIn      in   1                 low = freeze
// clearIn      in   1                 misprediction flush
// reqValid     in   NUM_CH            per-channel request
// reqReady     out  NUM_CH            per-channel accept (combinational)
// reqWrite     in   NUM_CH            1 = write
// reqLen       in   NUM_CH*LEN_W      byte count minus 1
// reqAddr      in   NUM_CH*32         start byte address
// reqData      in   NUM_CH*8*MAX_LEN  write data, little-endian
// respValid    out  NUM_CH            one-cycle completion pulse
// respData     out  8*MAX_LEN         read data, little-endian, valid with respValid
// memIn        in   8                 RAM/IO read byte (address issued previous cycle)
// memOut       out  8                 write byte
// memAddr      out  32                byte address
// memWrite     out  1                 1 = write this cycle
// ioBufferFull in   1                 UART tx buffer full
// busy         out  1                 transaction in progress
// BEHAVIOUR
// - Reset (resetIn=0, async): state IDLE, rrPtr=0, all outputs 0, respData=0.
// - States: IDLE -> XFER -> (read: DRAIN) -> RESP -> IDLE; IOWAIT and GAP are sub-states of XFER.
// - IDLE: winner = first valid channel at or after rrPtr (wrap mod NUM_CH); reqReady[winner]=readyIn.
//   - Accept edge: latch addr/len/write/data/channel; rrPtr <= winner+1 mod NUM_CH.
// - XFER, cycle k=0..len: memAddr=addr+k (32-bit wrap); write: memWrite=1, memOut=byte k.
//   - Read: byte k captured from memIn at the edge ending cycle k+1 into respData[8k+:8].
// - Read L bytes: DRAIN one cycle for the last capture; respValid in cycle L+2 after accept edge.
// - Write L bytes: respValid in cycle L+1.
// - Unused respData bytes are 0. RESP lasts exactly 1 cycle; the next grant is possible in the following IDLE cycle.
// - IO byte: memAddr[17:16]==2'b11.
//   - IO write with ioBufferFull=1: memWrite=0, memAddr held, k not advanced (IOWAIT).
//   - After each issued IO write byte: IO_GAP cycles with memWrite=0.
// - clearIn=1 with CLEAR_MASK[ch] set and a read active: abort at that edge to IDLE, no respValid, captured bytes dropped.
//   - Writes are never aborted. Masked channels get reqReady=0 while clearIn=1.
// - readyIn=0: state, k and rrPtr frozen; memWrite=0; reqReady=0.
//   - A byte whose address was issued in the last active cycle is still captured into respData on the first frozen edge.
//   - On resume that address is not re-issued.
// - busy=1 in every state except IDLE. memAddr/memOut = 0 in IDLE.
// - Simultaneous clearIn and readyIn=0: clear wins.
// - len=0: single-byte transaction.
// STRUCTURE
// - Package mem_arb_pkg: state enum (IDLE, XFER, IOWAIT, GAP, DRAIN, RESP), IO_SEL=2'b11, IO_ADDR_LSB=16.
// - Sub-module rr_arbiter (NUM_CH): one-hot grant from valid vector and rrPtr; rest in mem_arbiter.
// TESTING
// - ch0 read, addr 0x100, len 3, RAM 11 22 33 44 -> memAddr 0x100..0x103; respValid[0] in cycle 6 after accept; respData[31:0]=0x44332211.
// - ch0, ch1 both valid continuously, len 0 -> grants alternate 0,1,0,1; each respValid once per grant.
// - ch0 write 0x30000 'A', ioBufferFull=1 for 5 cycles -> memWrite=0 for 5 cycles, then a single write; IO_GAP idle cycle follows.
// - ch1 read len 15, clearIn pulsed at k=4 -> memWrite=0 throughout, IDLE next cycle, no respValid[1]; ch0 write unaffected by clearIn.
// - readyIn low 3 cycles mid-read of 4 bytes -> respData equals the no-stall result; no address issued twice.
// - resetIn asserted mid-write -> all outputs 0 immediately, no further memWrite; next request after release starts from ch0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the byte-serial memory arbiter.
//   state_t      controller states; IOWAIT and GAP are sub-states of XFER
//   IO_SEL       value of the address select field that marks an IO byte
//   IO_ADDR_LSB  lowest bit of the two-bit IO select field in a byte address
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        XFER   = 3'd1,
        IOWAIT = 3'd2,
        GAP    = 3'd3,
        DRAIN  = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam int         IO_ADDR_LSB = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection.
//   valid      per-channel request vector
//   ptr        channel with highest priority this cycle
//   grant      one-hot grant: first valid channel at or after ptr (wrapping)
//   grant_idx  binary index of the granted channel (0 when none)
//   any        at least one channel is valid
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              any
);

    int               idx;
    logic [PTR_W-1:0] idx_p;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        idx_p     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx   = (int'(ptr) + i) % NUM_CH;
            idx_p = PTR_W'(idx);
            if (!any && valid[idx_p]) begin
                grant[idx_p] = 1'b1;
                grant_idx    = idx_p;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller shared by NUM_CH requesters over an 8-bit
// RAM/IO bus. One transaction at a time; requesters are served round-robin.
//
// Handshake: a request is taken on the rising edge where reqValid[ch] and
// reqReady[ch] are both 1. reqReady is combinational, is only ever set for the
// single arbitration winner while IDLE, and the request fields must be stable
// while reqValid is high. Completion is a one-cycle respValid[ch] pulse; read
// data is on respData in that same cycle.
//
// Ports:
//   clockIn, resetIn      clock, asynchronous active-low reset
//   readyIn               0 freezes state, byte index and round-robin pointer
//   clearIn               flush: aborts reads of channels set in CLEAR_MASK
//   reqValid/Ready/Write  per-channel request handshake and direction
//   reqLen/Addr/Data      per-channel byte count-1, start address, write data
//   respValid, respData   completion pulse and little-endian read data
//   memIn/Out/Addr/Write  byte bus; memIn returns the byte addressed last cycle
//   ioBufferFull          UART tx buffer full, stalls IO writes
//   busy                  not IDLE
//   debug_state           current controller state
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                MAX_LEN    = 16,
    parameter int                IO_GAP     = 1,
    parameter logic [NUM_CH-1:0] CLEAR_MASK = 2'b10,
    localparam int               LEN_W      = $clog2(MAX_LEN)
) (
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic                      readyIn,
    input  logic                      clearIn,
    input  logic [NUM_CH-1:0]         reqValid,
    output logic [NUM_CH-1:0]         reqReady,
    input  logic [NUM_CH-1:0]         reqWrite,
    input  logic [NUM_CH*LEN_W-1:0]   reqLen,
    input  logic [NUM_CH*32-1:0]      reqAddr,
    input  logic [NUM_CH*8*MAX_LEN-1:0] reqData,
    output logic [NUM_CH-1:0]         respValid,
    output logic [8*MAX_LEN-1:0]      respData,
    input  logic [7:0]                memIn,
    output logic [7:0]                memOut,
    output logic [31:0]               memAddr,
    output logic                      memWrite,
    input  logic                      ioBufferFull,
    output logic                      busy,
    output state_t                    debug_state
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = (IO_GAP > 1) ? $clog2(IO_GAP) : 1;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       cur_ch;
    logic                   cur_write;
    logic [LEN_W-1:0]       cur_len;
    logic [31:0]            cur_addr;
    logic [8*MAX_LEN-1:0]   cur_data;
    logic [LEN_W-1:0]       k;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   pend;
    logic [LEN_W-1:0]       pend_idx;
    logic [8*MAX_LEN-1:0]   resp_data;

    // Arbitration; flushable channels sit out while clearIn is high.
    logic [NUM_CH-1:0] arb_valid;
    logic [NUM_CH-1:0] arb_grant;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_any;
    logic [PTR_W-1:0]  next_ptr;

    assign arb_valid = reqValid & ~({NUM_CH{clearIn}} & CLEAR_MASK);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .valid     (arb_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign next_ptr = (arb_idx == PTR_W'(NUM_CH - 1)) ? '0 : arb_idx + PTR_W'(1);

    // Request fields of the winning channel.
    logic                 sel_write;
    logic [LEN_W-1:0]     sel_len;
    logic [31:0]          sel_addr;
    logic [8*MAX_LEN-1:0] sel_data;

    always_comb begin
        sel_write = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_idx == PTR_W'(i)) begin
                sel_write = reqWrite[i];
                sel_len   = reqLen[i*LEN_W +: LEN_W];
                sel_addr  = reqAddr[i*32 +: 32];
                sel_data  = reqData[i*8*MAX_LEN +: 8*MAX_LEN];
            end
        end
    end

    // Datapath decode of the current byte.
    logic [31:0] cur_byte_addr;
    logic        cur_io;
    logic        in_xfer;
    logic        io_stall;
    logic        issue;
    logic        abort;

    assign cur_byte_addr = cur_addr + 32'(k);
    assign cur_io        = (cur_byte_addr[IO_ADDR_LSB +: 2] == IO_SEL);
    assign in_xfer       = (state == XFER) || (state == IOWAIT);
    assign io_stall      = cur_write && cur_io && ioBufferFull;
    assign issue         = in_xfer && readyIn && !io_stall;
    // Only reads of flushable channels are aborted, and only while they still
    // have bytes outstanding (XFER or DRAIN). Clear overrides a freeze.
    assign abort         = clearIn && CLEAR_MASK[cur_ch] && !cur_write &&
                           ((state == XFER) || (state == DRAIN));

    assign reqReady    = (state == IDLE && readyIn && resetIn) ? arb_grant : '0;
    assign memWrite    = issue && cur_write;
    assign memAddr     = (in_xfer || state == GAP) ? cur_byte_addr : 32'd0;
    assign memOut      = ((in_xfer || state == GAP) && cur_write) ?
                         cur_data[{k, 3'b000} +: 8] : 8'd0;
    assign respValid   = (state == RESP) ? (NUM_CH'(1) << cur_ch) : '0;
    assign respData    = resp_data;
    assign busy        = (state != IDLE);
    assign debug_state = state;

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_ch    <= '0;
            cur_write <= 1'b0;
            cur_len   <= '0;
            cur_addr  <= '0;
            cur_data  <= '0;
            k         <= '0;
            gap_cnt   <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            resp_data <= '0;
        end else begin
            // A byte addressed in the previous active cycle lands now, even if
            // this edge is frozen; that address is never issued again.
            if (pend) begin
                resp_data[{pend_idx, 3'b000} +: 8] <= memIn;
            end
            pend <= 1'b0;

            if (abort) begin
                state     <= IDLE;
                resp_data <= '0;
            end else if (readyIn) begin
                case (state)
                    IDLE: begin
                        if (arb_any) begin
                            cur_ch    <= arb_idx;
                            cur_write <= sel_write;
                            cur_len   <= sel_len;
                            cur_addr  <= sel_addr;
                            cur_data  <= sel_data;
                            k         <= '0;
                            resp_data <= '0;
                            rr_ptr    <= next_ptr;
                            state     <= XFER;
                        end
                    end
                    XFER, IOWAIT: begin
                        if (io_stall) begin
                            state <= IOWAIT;
                        end else begin
                            if (!cur_write) begin
                                pend     <= 1'b1;
                                pend_idx <= k;
                            end
                            // k is held through the gap and advanced on exit.
                            if (cur_write && cur_io && (IO_GAP > 0)) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else if (k == cur_len) begin
                                state <= cur_write ? RESP : DRAIN;
                            end else begin
                                k     <= k + LEN_W'(1);
                                state <= XFER;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_W'(IO_GAP - 1)) begin
                            if (k == cur_len) begin
                                state <= RESP;
                            end else begin
                                k     <= k + LEN_W'(1);
                                state <= XFER;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    DRAIN:   state <= RESP;
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clockIn = 1'b0;
  logic         resetIn;
  logic         readyIn;
  logic         clearIn;
  logic [1:0]   reqValid;
  logic [1:0]   reqReady;
  logic [1:0]   reqWrite;
  logic [7:0]   reqLen;
  logic [63:0]  reqAddr;
  logic [255:0] reqData;
  logic [1:0]   respValid;
  logic [127:0] respData;
  logic [7:0]   memIn;
  logic [7:0]   memOut;
  logic [31:0]  memAddr;
  logic         memWrite;
  logic         ioBufferFull;
  logic         busy;
  state_t       debug_state;

  always #5 clockIn = ~clockIn;

  mem_arbiter dut (
    .clockIn      (clockIn),
    .resetIn      (resetIn),
    .readyIn      (readyIn),
    .clearIn      (clearIn),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqLen       (reqLen),
    .reqAddr      (reqAddr),
    .reqData      (reqData),
    .respValid    (respValid),
    .respData     (respData),
    .memIn        (memIn),
    .memOut       (memOut),
    .memAddr      (memAddr),
    .memWrite     (memWrite),
    .ioBufferFull (ioBufferFull),
    .busy         (busy),
    .debug_state  (debug_state)
  );

  // ---------------- memory model (synchronous read) ----------------
  logic [7:0] ram [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 5);
    ram[12'h100] = 8'h11;
    ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33;
    ram[12'h103] = 8'h44;
  end

  always @(posedge clockIn) memIn <= ram[memAddr[11:0]];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [129:0] exp_resp_q[$];   // {respValid, respData}
  logic [39:0]  exp_wr_q[$];     // {memAddr, memOut}
  logic [31:0]  rd_log[$];       // read addresses issued in active cycles

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response or a write byte.
  always @(negedge clockIn) begin
    if (resetIn === 1'b1) begin
      if (respValid !== 2'b00) begin
        if (exp_resp_q.size() == 0) check("resp_unexpected", {respValid, respData}, 160'd0);
        else check("resp", {respValid, respData}, exp_resp_q.pop_front());
      end
      if (memWrite === 1'b1) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", {memAddr, memOut}, 160'd0);
        else check("wr", {memAddr, memOut}, exp_wr_q.pop_front());
      end
      if (debug_state == XFER && readyIn && !memWrite) rd_log.push_back(memAddr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int ch, input bit wr, input int len, input logic [31:0] addr,
                       input logic [127:0] data, input string name);
    bit ok;
    reqWrite[ch]           = wr;
    reqLen[ch*4 +: 4]      = 4'(len);
    reqAddr[ch*32 +: 32]   = addr;
    reqData[ch*128 +: 128] = data;
    reqValid[ch]           = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clockIn);
      if (reqReady[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 160'(ok), 160'd1);
    @(posedge clockIn); #1;
    reqValid[ch] = 1'b0;
  endtask

  // Counts cycles from the first cycle after the accept edge to respValid[ch].
  task automatic wait_resp(input int ch, input int lat, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clockIn);
      if (respValid[ch]) begin
        n = i;
        break;
      end
    end
    check(name, 160'(n), 160'(lat));
    @(posedge clockIn); #1;
  endtask

  task automatic check_rd_log(input logic [31:0] base, input int n, input string name);
    check({name, "_n"}, 160'(rd_log.size()), 160'(n));
    for (int i = 0; i < n && i < rd_log.size(); i++)
      check({name, "_addr"}, 160'(rd_log[i]), 160'(base + 32'(i)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] gv;
    int         nw;
    int         bad;

    resetIn      = 1'b0;
    readyIn      = 1'b1;
    clearIn      = 1'b0;
    reqValid     = 2'b11;
    reqWrite     = '0;
    reqLen       = '0;
    reqAddr      = '0;
    reqData      = '0;
    ioBufferFull = 1'b0;

    // Reset state
    repeat (3) @(negedge clockIn);
    check("rst_ready", 160'(reqReady), 160'd0);
    check("rst_busy", 160'(busy), 160'd0);
    check("rst_bus", {memWrite, memAddr, memOut}, 160'd0);
    check("rst_resp", {respValid, respData}, 160'd0);
    check("rst_state", 160'(debug_state), 160'(IDLE));
    reqValid = 2'b00;
    @(posedge clockIn); #1;
    resetIn = 1'b1;
    @(posedge clockIn); #1;

    // Round-robin: both channels valid continuously, len 0 reads
    reqAddr[31:0]  = 32'h200;
    reqAddr[63:32] = 32'h300;
    reqValid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      gv = 2'b00;
      for (int i = 0; i < 100; i++) begin
        @(negedge clockIn);
        if ((reqValid & reqReady) != 2'b00) begin
          gv = reqReady;
          break;
        end
      end
      check("alt_grant", 160'(gv), (g % 2 == 0) ? 160'd1 : 160'd2);
      if (g % 2 == 0) exp_resp_q.push_back({2'b01, 120'd0, ram[12'h200]});
      else            exp_resp_q.push_back({2'b10, 120'd0, ram[12'h300]});
      @(posedge clockIn); #1;
      if (g == 3) reqValid = 2'b00;
    end
    wait_resp(1, 3, "alt_last_lat");

    // ch0 read of 4 bytes at 0x100
    rd_log.delete();
    exp_resp_q.push_back({2'b01, 128'h44332211});
    issue(0, 1'b0, 3, 32'h100, 128'd0, "rd4_grant");
    wait_resp(0, 6, "rd4_lat");
    check_rd_log(32'h100, 4, "rd4");

    // ch1 single-byte read: upper respData bytes must be cleared
    exp_resp_q.push_back({2'b10, 120'd0, ram[12'h300]});
    issue(1, 1'b0, 0, 32'h300, 128'd0, "rd1_grant");
    wait_resp(1, 3, "rd1_lat");

    // IO write with UART buffer full for 5 cycles
    ioBufferFull = 1'b1;
    exp_wr_q.push_back({32'h30000, 8'h41});
    exp_resp_q.push_back({2'b01, 128'd0});
    issue(0, 1'b1, 0, 32'h30000, 128'h41, "io_grant");
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clockIn);
      if (memWrite) nw++;
      if (i == 2) check("io_hold_addr", 160'(memAddr), 160'h30000);
    end
    check("io_stall_nwr", 160'(nw), 160'd0);
    @(posedge clockIn); #1;
    ioBufferFull = 1'b0;
    @(negedge clockIn);
    check("io_write", 160'(memWrite), 160'd1);
    @(negedge clockIn);
    check("io_gap", {respValid, busy, memWrite}, 160'b0010);
    @(negedge clockIn);
    check("io_resp", 160'(respValid), 160'd1);
    @(posedge clockIn); #1;

    // clearIn hides the flushable channel from arbitration
    clearIn = 1'b1;
    reqWrite[1] = 1'b0;
    reqValid = 2'b10;
    @(negedge clockIn);
    check("clr_mask_ready", 160'(reqReady), 160'd0);
    @(posedge clockIn); #1;
    reqValid = 2'b00;
    clearIn  = 1'b0;
    @(negedge clockIn);
    check("clr_no_accept", 160'(busy), 160'd0);
    @(posedge clockIn); #1;

    // ch1 16-byte read aborted by clearIn at k=4
    issue(1, 1'b0, 15, 32'h400, 128'd0, "clr_grant");
    repeat (4) @(posedge clockIn);
    #1 clearIn = 1'b1;
    @(negedge clockIn);
    check("clr_addr_k4", 160'(memAddr), 160'h404);
    @(posedge clockIn); #1;
    clearIn = 1'b0;
    @(negedge clockIn);
    check("clr_idle", 160'(busy), 160'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clockIn);
      if (respValid != 2'b00 || memWrite) bad++;
    end
    check("clr_silent", 160'(bad), 160'd0);
    @(posedge clockIn); #1;

    // ch0 2-byte write under clearIn is not aborted
    clearIn = 1'b1;
    exp_wr_q.push_back({32'h500, 8'hAA});
    exp_wr_q.push_back({32'h501, 8'hBB});
    exp_resp_q.push_back({2'b01, 128'd0});
    issue(0, 1'b1, 1, 32'h500, 128'hBBAA, "clrwr_grant");
    wait_resp(0, 3, "clrwr_lat");
    clearIn = 1'b0;

    // readyIn low for 3 cycles in the middle of a 4-byte read
    rd_log.delete();
    exp_resp_q.push_back({2'b01, 128'h44332211});
    issue(0, 1'b0, 3, 32'h100, 128'd0, "stall_grant");
    @(posedge clockIn); #1;
    @(posedge clockIn); #1;
    readyIn = 1'b0;
    @(negedge clockIn);
    check("stall_busy_wr", {busy, memWrite, reqReady}, 160'b1000);
    repeat (3) @(posedge clockIn);
    #1 readyIn = 1'b1;
    wait_resp(0, 4, "stall_lat");
    check_rd_log(32'h100, 4, "stall");

    // Reset mid-write, then arbitration restarts from ch0
    exp_wr_q.push_back({32'h600, 8'hD0});
    exp_wr_q.push_back({32'h601, 8'hD1});
    issue(0, 1'b1, 3, 32'h600, 128'hD3D2D1D0, "rstwr_grant");
    @(negedge clockIn);
    @(negedge clockIn);
    #1 resetIn = 1'b0;
    #1;
    check("rstmid_busy", 160'(busy), 160'd0);
    check("rstmid_bus", {memWrite, memAddr, memOut}, 160'd0);
    check("rstmid_resp", {respValid, respData, reqReady}, 160'd0);
    @(negedge clockIn);
    resetIn = 1'b1;
    @(posedge clockIn); #1;
    reqWrite = 2'b00;
    reqLen   = '0;
    reqAddr[31:0]  = 32'h210;
    reqAddr[63:32] = 32'h310;
    reqValid = 2'b11;
    gv = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clockIn);
      if ((reqValid & reqReady) != 2'b00) begin
        gv = reqReady;
        break;
      end
    end
    check("post_rst_grant", 160'(gv), 160'd1);
    exp_resp_q.push_back({2'b01, 120'd0, ram[12'h210]});
    @(posedge clockIn); #1;
    reqValid = 2'b00;
    wait_resp(0, 3, "post_rst_lat");
    repeat (5) @(posedge clockIn);

    check("resp_q_empty", 160'(exp_resp_q.size()), 160'd0);
    check("wr_q_empty", 160'(exp_wr_q.size()), 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
